dm_wbuf: RTL and testbench
==========================

DM_WBUF -- requirements
Module: dm_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, number of posted-write buffer entries (power of two, 2..8).
REQ-002 Parameter AW, default 12, word address width (matches DM_address).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 DM_enable  input  1  core data-memory access qualifier.
REQ-006 DM_read  input  1  core read request, valid only with DM_enable.
REQ-007 DM_write  input  1  core write request, valid only with DM_enable.
REQ-008 DM_address  input  AW  core word address.
REQ-009 DM_in  input  32  core write data.
REQ-010 DM_out  output  32  read data returned to core.
REQ-011 DM_rvalid  output  1  DM_out valid, one-cycle pulse.
REQ-012 DM_stall  output  1  core request not accepted this cycle; core holds request stable.
REQ-013 mem_req  output  1  backing-memory request.
REQ-014 mem_we  output  1  backing-memory write (1) / read (0).
REQ-015 mem_addr  output  AW  backing-memory address.
REQ-016 mem_wdata  output  32  backing-memory write data.
REQ-017 mem_rdata  input  32  backing-memory read data, valid with mem_ack on read.
REQ-018 mem_ack  input  1  backing-memory completion, one-cycle pulse.

Function
REQ-019 Request accepted when DM_enable=1 and DM_stall=0; DM_read and DM_write both high treated as write only.
REQ-020 Accepted write enters buffer tail same cycle; no backing-memory wait for core.
REQ-021 Write with buffer full: DM_stall=1 until an entry retires; entry retiring and write arriving in same cycle when full: write accepted that cycle.
REQ-022 Controller FSM states IDLE, WR_BUSY, RD_BUSY, RD_RESP.
REQ-023 IDLE: pending read miss has priority over drain; else buffer non-empty -> issue head write, go WR_BUSY.
REQ-024 WR_BUSY: mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry, held stable; on mem_ack head pops, return IDLE.
REQ-025 RD_BUSY: mem_req=1, mem_we=0, mem_addr = captured read address; on mem_ack capture mem_rdata, go RD_RESP.
REQ-026 RD_RESP: DM_out = captured data, DM_rvalid=1 for exactly one cycle, return IDLE.
REQ-027 Read accepted only in IDLE; DM_stall=1 for read in any other state and for read in IDLE while read blocked per REQ-036.
REQ-028 Read miss latency: DM_rvalid asserted cycle after mem_ack cycle.
REQ-029 Buffer pointers wrap modulo DEPTH; count field DEPTH+1 values distinguishes full/empty.
REQ-030 Writes retire to backing memory in acceptance order; consecutive writes to same address both retire.
REQ-031 mem_ack outside WR_BUSY/RD_BUSY ignored.
REQ-032 DM_out holds last returned value between DM_rvalid pulses.

Reset
REQ-033 rst low: FSM IDLE, buffer empty, pointers 0, DM_out=0, DM_rvalid=0, DM_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset mid-transaction abandons in-flight access and all buffered writes; first post-reset mem_ack ignored unless new request issued.

Configuration
REQ-035 Macro DM_WBUF_FORWARD_EN defined: read in IDLE whose address matches any buffer entry returns data of youngest matching entry, DM_rvalid next cycle, no backing-memory access; non-matching read issues RD_BUSY ahead of buffered writes.
REQ-036 Macro undefined: read stalls (DM_stall=1) until buffer empty, then issues RD_BUSY; no address comparators present.
REQ-037 Forwarded read and write accepted same cycle impossible (single request port); write accepted in cycle N visible to read in cycle N+1.

Verification
REQ-038 Reset, write 0x11 to addr 0x004, mem_ack 2 cycles after each mem_req -> mem_req/mem_we=1, mem_addr=0x004, mem_wdata=0x11, core never stalled.
REQ-039 Five writes back-to-back, DEPTH=4, mem_ack withheld -> DM_stall=1 on fifth until first mem_ack, then accepted; memory sees addresses in issue order.
REQ-040 FORWARD_EN: write 0xAB to 0x010, write 0xCD to 0x010, read 0x010 -> DM_out=0xCD, DM_rvalid 1 cycle after acceptance, mem_we=0 never asserted for read.
REQ-041 FORWARD_EN off: two buffered writes, read 0x020 -> DM_stall=1 until both acks, then mem_req read 0x020, mem_rdata=0x5A -> DM_out=0x5A next cycle.
REQ-042 rst low during WR_BUSY with 3 entries -> all outputs reset values, buffer empty, stray mem_ack no effect, no further mem_req.

Source files
------------

// File: rtl/dm_wbuf.sv
// -----------------------------------------------------------------------------
// dm_wbuf -- posted-write buffer between a core data-memory port and a
// single-ported backing memory.
//
// Writes are accepted into a DEPTH-entry FIFO without waiting for memory and
// drained in acceptance order. Reads go to memory one at a time. A single
// controller FSM (IDLE / WR_BUSY / RD_BUSY / RD_RESP) owns the memory port.
//
// Optional feature (macro DM_WBUF_FORWARD_EN):
//   defined   : a read in IDLE that hits a buffered address is answered from
//               the youngest matching entry. A miss goes to memory ahead of
//               the buffered writes.
//   undefined : a read waits until the buffer is empty. No address
//               comparators are built.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   DM_enable/read/write  core request qualifiers (read+write = write)
//   DM_address, DM_in     core word address and write data
//   DM_out, DM_rvalid     read data (held) and one-cycle valid pulse
//   DM_stall              core request not accepted this cycle
//   mem_req, mem_we       backing-memory request, write(1)/read(0)
//   mem_addr, mem_wdata   backing-memory address and write data
//   mem_rdata, mem_ack    backing-memory read data and completion pulse
// -----------------------------------------------------------------------------
module dm_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DM_enable,
  input  logic          DM_read,
  input  logic          DM_write,
  input  logic [AW-1:0] DM_address,
  input  logic [31:0]   DM_in,
  output logic [31:0]   DM_out,
  output logic          DM_rvalid,
  output logic          DM_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] buf_addr_q [DEPTH];
  logic [31:0]   buf_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]   dm_out_q, dm_out_d;

  logic        wr_req, rd_req, buf_full, buf_empty;
  logic        push, pop, rd_stall, rd_accept;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  // Simultaneous read and write is treated as a write.
  assign wr_req    = DM_enable & DM_write;
  assign rd_req    = DM_enable & DM_read & ~DM_write;
  assign buf_full  = (count_q == CW'(DEPTH));
  assign buf_empty = (count_q == '0);

  // An entry retiring this cycle frees a slot for a write arriving while full.
  assign pop  = (state_q == WR_BUSY) & mem_ack;
  assign push = wr_req & (~buf_full | pop);

`ifdef DM_WBUF_FORWARD_EN
  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (buf_addr_q[head_q + PW'(i)] == DM_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[head_q + PW'(i)];
      end
    end
  end
  assign rd_stall = (state_q != IDLE);
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // Without forwarding a read must not overtake buffered writes.
  assign rd_stall = (state_q != IDLE) | ~buf_empty;
`endif

  assign rd_accept = rd_req & ~rd_stall;
  assign DM_stall  = wr_req ? ~push : (rd_req & rd_stall);

  // Pointers are PW bits wide, so wrap modulo DEPTH is free.
  assign head_d = pop  ? head_q + PW'(1) : head_q;
  assign tail_d = push ? tail_q + PW'(1) : tail_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Controller: an accepted read wins over draining the buffer.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    dm_out_d  = dm_out_q;
    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          if (fwd_hit) begin
            dm_out_d = fwd_data;
            state_d  = RD_RESP;
          end else begin
            rd_addr_d = DM_address;
            state_d   = RD_BUSY;
          end
        end else if (!buf_empty) begin
          state_d = WR_BUSY;
        end
      end
      WR_BUSY: if (mem_ack) state_d = IDLE;
      RD_BUSY: begin
        if (mem_ack) begin
          dm_out_d = mem_rdata;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      dm_out_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      dm_out_q  <= dm_out_d;
    end
  end

  // NOTE: buffer storage has no reset; count_q alone marks entries valid,
  // which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[tail_q] <= DM_address;
      buf_data_q[tail_q] <= DM_in;
    end
  end

  // Memory-side outputs are decoded from state so they are stable for the
  // whole transaction and zero when idle.
  assign mem_req   = (state_q == WR_BUSY) | (state_q == RD_BUSY);
  assign mem_we    = (state_q == WR_BUSY);
  assign mem_addr  = (state_q == WR_BUSY) ? buf_addr_q[head_q] :
                     (state_q == RD_BUSY) ? rd_addr_q : '0;
  assign mem_wdata = (state_q == WR_BUSY) ? buf_data_q[head_q] : '0;
  assign DM_rvalid = (state_q == RD_RESP);
  assign DM_out    = dm_out_q;

endmodule

// File: tb/tb_dm_wbuf.sv
// -----------------------------------------------------------------------------
// tb_dm_wbuf -- self-checking bench for dm_wbuf.
// A transaction-level model (queue of posted writes, program-order shadow
// memory, read bookkeeping) predicts stall, read data and memory-side traffic
// every cycle. The bench also plays the backing memory. Directed scenarios
// pin the model with literal values, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_dm_wbuf;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
`ifdef DM_WBUF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          DM_enable, DM_read, DM_write;
  logic [AW-1:0] DM_address;
  logic [31:0]   DM_in, DM_out;
  logic          DM_rvalid, DM_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ack;

  dm_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in),
    .DM_out(DM_out), .DM_rvalid(DM_rvalid), .DM_stall(DM_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ent_t;

  // Model state
  ent_t          q[$];
  logic [31:0]   shadow[int];
  logic          rd_pending = 1'b0, rd_miss = 1'b0, rv_due = 1'b0;
  logic [AW-1:0] rd_addr_m = '0;
  logic [31:0]   rd_exp = '0, out_exp = '0;

  // Backing-memory model and its controls
  logic [31:0] mem[int];
  bit          ack_hold = 1'b0, rand_delay = 1'b0, stray_en = 1'b0, stray_now = 1'b0;
  int          ack_delay = 2;
  int          wr_log[$];
  int          rd_count = 0;

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return 32'h3C00_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backing memory: acks after ack_delay cycles of mem_req, optional stray acks.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      tick();
      mem_ack = 1'b0;
      if (!rst) begin
        wait_cnt = 0;
      end else if (!mem_req && (stray_now || (stray_en && $urandom_range(0, 7) == 0))) begin
        stray_now = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end else if (mem_req && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            mem[int'(mem_addr)] = mem_wdata;
            wr_log.push_back(int'(mem_addr));
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : init_val(mem_addr);
            rd_count++;
          end
          if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin
    logic wr_fly, wr_ret, rd_done, acc_w, acc_r, exp_stall, nx_rv, hit;
    logic [31:0] out_next, hv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        shadow     = mem;
        rd_pending = 1'b0;
        rd_miss    = 1'b0;
        rv_due     = 1'b0;
        out_exp    = '0;
        check("rst_dm_out", DM_out, 32'h0);
        check("rst_rvalid", DM_rvalid, 1'b0);
        check("rst_stall", DM_stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        continue;
      end
      wr_fly  = mem_req && mem_we;
      wr_ret  = wr_fly && mem_ack;
      rd_done = mem_req && !mem_we && mem_ack;
      exp_stall = 1'b0;
      if (DM_enable) begin
        if (DM_write)     exp_stall = (q.size() == DEPTH) && !wr_ret;
        else if (DM_read) exp_stall = rd_pending || wr_fly || (!FWD && q.size() != 0);
      end
      check("stall", DM_stall, exp_stall);
      check("rvalid", DM_rvalid, rv_due);
      check("dm_out", DM_out, out_exp);
      if (mem_req) begin
        if (mem_we) begin
          check("wr_has_entry", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            check("wr_addr", mem_addr, q[0].addr);
            check("wr_data", mem_wdata, q[0].data);
          end
        end else begin
          check("rd_issue", rd_miss, 1'b1);
          check("rd_addr", mem_addr, rd_addr_m);
        end
      end

      acc_w    = DM_enable && DM_write && !DM_stall;
      acc_r    = DM_enable && DM_read && !DM_write && !DM_stall;
      nx_rv    = 1'b0;
      out_next = out_exp;
      if (wr_ret && q.size() != 0) void'(q.pop_front());
      if (rv_due) rd_pending = 1'b0;
      if (rd_done && rd_miss) begin
        nx_rv    = 1'b1;
        out_next = rd_exp;
        rd_miss  = 1'b0;
      end
      if (acc_w) begin
        q.push_back('{addr: DM_address, data: DM_in});
        shadow[int'(DM_address)] = DM_in;
      end else if (acc_r) begin
        hit = 1'b0;
        hv  = '0;
        if (FWD) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr == DM_address) begin
              hit = 1'b1;
              hv  = q[i].data;
            end
          end
        end
        rd_pending = 1'b1;
        if (hit) begin
          nx_rv    = 1'b1;
          out_next = hv;
        end else begin
          rd_miss   = 1'b1;
          rd_addr_m = DM_address;
          rd_exp    = shadow.exists(int'(DM_address)) ? shadow[int'(DM_address)]
                                                      : init_val(DM_address);
        end
      end
      rv_due  = nx_rv;
      out_exp = out_next;
    end
  end

  task automatic core_idle();
    DM_enable = 1'b0;
    DM_read   = 1'b0;
    DM_write  = 1'b0;
  endtask

  task automatic do_req(input bit is_wr, input logic [AW-1:0] a, input logic [31:0] d,
                        output int stalls);
    bit st;
    stalls     = 0;
    DM_enable  = 1'b1;
    DM_write   = is_wr;
    DM_read    = !is_wr;
    DM_address = a;
    DM_in      = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      st = DM_stall;
      tick();
      if (!st) break;
      stalls++;
    end
    check("req_accepted", stalls < 200, 1'b1);
    core_idle();
  endtask

  task automatic wait_rvalid(input string name, input logic [31:0] exp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (DM_rvalid) begin
        seen = 1'b1;
        check(name, DM_out, exp);
      end
      tick();
      if (seen) break;
    end
    check({name, "_seen"}, seen, 1'b1);
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 200 && wr_log.size() < n; k++) tick();
    check("writes_retired", wr_log.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  st, base, rc0, k_acc;
    bit  s;
    rst = 1'b0;
    core_idle();
    DM_address = '0;
    DM_in      = '0;

    // Reset state, literal values
    repeat (3) @(negedge clk);
    check("lit_rst_mem_req", mem_req, 1'b0);
    check("lit_rst_dm_out", DM_out, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single posted write reaches memory, no stall
    ack_delay = 2;
    do_req(1'b1, 12'h004, 32'h11, st);
    check("w1_no_stall", st, 0);
    s = 1'b0;
    for (int k = 0; k < 10 && !s; k++) begin
      @(negedge clk);
      if (mem_req) begin
        s = 1'b1;
        check("w1_mem_we", mem_we, 1'b1);
        check("w1_mem_addr", mem_addr, 12'h004);
        check("w1_mem_wdata", mem_wdata, 32'h11);
      end
      tick();
    end
    check("w1_mem_req_seen", s, 1'b1);
    wait_writes(1);

    // Five back-to-back writes with acks withheld: fifth stalls until first ack
    wr_log.delete();
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, AW'(12'h100 + 4 * i), 32'hA000 + i, st);
      check("full_fill_no_stall", st, 0);
    end
    DM_enable  = 1'b1;
    DM_write   = 1'b1;
    DM_address = 12'h110;
    DM_in      = 32'hA004;
    k_acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s = DM_stall;
      if (k < 3) check("full_fifth_stalls", s, 1'b1);
      if (k == 2) begin
        ack_hold  = 1'b0;
        ack_delay = 0;
      end
      tick();
      if (!s) begin
        k_acc = k;
        break;
      end
    end
    check("full_accept_on_first_ack", k_acc, 3);
    core_idle();
    ack_delay = 2;
    wait_writes(5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++)
      check("full_order", wr_log[i], 32'h100 + 4 * i);

`ifdef DM_WBUF_FORWARD_EN
    // Forwarding returns the youngest buffered value without a memory read
    ack_delay = 3;
    do_req(1'b1, 12'h010, 32'hAB, st);
    do_req(1'b1, 12'h010, 32'hCD, st);
    rc0 = rd_count;
    do_req(1'b0, 12'h010, 32'h0, st);
    @(negedge clk);
    check("fwd_rvalid_next", DM_rvalid, 1'b1);
    check("fwd_data", DM_out, 32'hCD);
    tick();
    repeat (15) tick();
    check("fwd_no_mem_read", rd_count, rc0);
`else
    // Read waits for the buffer to drain, then goes to memory
    mem[32'h20]    = 32'h5A;
    shadow[32'h20] = 32'h5A;
    ack_delay = 2;
    base = wr_log.size();
    do_req(1'b1, 12'h030, 32'h1, st);
    do_req(1'b1, 12'h034, 32'h2, st);
    do_req(1'b0, 12'h020, 32'h0, st);
    check("nofwd_read_stalled", st > 0, 1'b1);
    check("nofwd_drained_first", wr_log.size(), base + 2);
    wait_rvalid("nofwd_data", 32'h5A);
`endif

    // Reset during WR_BUSY with three entries abandons everything
    repeat (5) tick();
    ack_hold = 1'b1;
    do_req(1'b1, 12'h040, 32'hE0, st);
    do_req(1'b1, 12'h044, 32'hE1, st);
    do_req(1'b1, 12'h048, 32'hE2, st);
    s = 1'b0;
    for (int k = 0; k < 10 && !s; k++) begin
      @(negedge clk);
      s = mem_req && mem_we;
      tick();
    end
    check("rstmid_wr_busy_seen", s, 1'b1);
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rstmid_mem_req", mem_req, 1'b0);
    check("rstmid_mem_addr", mem_addr, '0);
    check("rstmid_stall", DM_stall, 1'b0);
    tick();
    rst       = 1'b1;
    ack_hold  = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    stray_now = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rstmid_no_req", mem_req, 1'b0);
      tick();
    end
    do_req(1'b0, 12'h044, 32'h0, st);
    check("rstmid_read_no_stall", st, 0);
    wait_rvalid("rstmid_read_mem", init_val(12'h044));

    // Randomized traffic with random ack latency, stray acks and one reset
    rand_delay = 1'b1;
    stray_en   = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r, kind;
      @(negedge clk);
      s = DM_stall;
      tick();
      if (c == 1500) rst = 1'b0;
      if (c == 1502) rst = 1'b1;
      if (!(DM_enable && s)) begin
        r    = $urandom_range(0, 9);
        kind = $urandom_range(0, 9);
        DM_enable  = (r < 6);
        DM_write   = (kind < 6) || (kind == 9);
        DM_read    = (kind >= 6);
        DM_address = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7) * 4);
        DM_in      = $urandom;
      end
    end
    core_idle();
    stray_en = 1'b0;
    repeat (60) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
